easyaxi_rd_slice: RTL and testbench

//  AXI read-channel register slice sitting between EASYAXI_MST and EASYAXI_SLV in EASYAXI_TOP.

---
 rtl/easyaxi_rd_slice_pkg.sv | 43 ++++
 rtl/easyaxi_skid_buf.sv | 57 +++++
 rtl/easyaxi_rd_slice.sv | 105 ++++++++++
 tb/tb_easyaxi_rd_slice.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/easyaxi_rd_slice_pkg.sv
// Shared AXI widths plus packed AR/R payload types for the read-channel slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef AXI_ID_W
`define AXI_ID_W     4
`define AXI_ADDR_W   32
`define AXI_LEN_W    8
`define AXI_SIZE_W   3
`define AXI_BURST_W  2
`define AXI_DATA_W   32
`define AXI_RESP_W   2
`endif
`ifndef AXI_AR_PLD_W
`define AXI_AR_PLD_W (`AXI_ID_W + `AXI_ADDR_W + `AXI_LEN_W + `AXI_SIZE_W + `AXI_BURST_W)
`define AXI_R_PLD_W  (`AXI_ID_W + `AXI_DATA_W + `AXI_RESP_W + 1)
`endif

package easyaxi_rd_slice_pkg;
    localparam int ID_W     = `AXI_ID_W;
    localparam int ADDR_W   = `AXI_ADDR_W;
    localparam int LEN_W    = `AXI_LEN_W;
    localparam int SIZE_W   = `AXI_SIZE_W;
    localparam int BURST_W  = `AXI_BURST_W;
    localparam int DATA_W   = `AXI_DATA_W;
    localparam int RESP_W   = `AXI_RESP_W;
    localparam int AR_PLD_W = `AXI_AR_PLD_W;
    localparam int R_PLD_W  = `AXI_R_PLD_W;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } ar_pld_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [RESP_W-1:0] resp;
        logic              last;
    } r_pld_t;
endpackage

// File: rtl/easyaxi_skid_buf.sv
// Two-entry skid buffer on a valid/ready channel: main entry drives out, skid entry absorbs a stall.
// Latency: 1 cycle in->out, full throughput, no bubbles.
// Backpressure: in_ready is a flop (skid entry empty), never combinational from out_ready.
module easyaxi_skid_buf #(
    parameter int PLD_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PLD_W-1:0] in_pld,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PLD_W-1:0] out_pld
);
    logic             m_vld, s_vld, in_rdy_q;
    logic [PLD_W-1:0] m_dat, s_dat;
    logic             push, pop, m_load, s_vld_nxt;

    assign push   = in_valid & in_rdy_q;
    assign pop    = m_vld & out_ready;
    // Main entry refills whenever it is empty or being drained this cycle.
    assign m_load = !m_vld || pop;

    always_comb begin
        s_vld_nxt = s_vld;
        if (m_load)
            s_vld_nxt = 1'b0;
        else if (push)
            s_vld_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld    <= 1'b0;
            s_vld    <= 1'b0;
            in_rdy_q <= 1'b0;
        end else begin
            s_vld    <= s_vld_nxt;
            in_rdy_q <= !s_vld_nxt;
            if (m_load)
                m_vld <= s_vld || push;
        end
    end

    // Payload flops carry no reset; they are only meaningful under their valid.
    always_ff @(posedge clk) begin
        if (m_load && (s_vld || push))
            m_dat <= s_vld ? s_dat : in_pld;
        if (!m_load && push)
            s_dat <= in_pld;
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = m_vld;
    assign out_pld   = m_dat;
endmodule

// File: rtl/easyaxi_rd_slice.sv
// AXI read-channel register slice: skid buffers on AR and R plus an outstanding-burst limiter.
// Latency: 1 cycle per channel, 1 beat/cycle each direction.
// Backpressure: up_arready drops on AR skid full or outs_cnt == MAX_OUTS; R is never throttled.
module easyaxi_rd_slice
    import easyaxi_rd_slice_pkg::*;
#(
    parameter int MAX_OUTS = 4,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up_arvalid,
    output logic               up_arready,
    input  logic [ID_W-1:0]    up_arid,
    input  logic [ADDR_W-1:0]  up_araddr,
    input  logic [LEN_W-1:0]   up_arlen,
    input  logic [SIZE_W-1:0]  up_arsize,
    input  logic [BURST_W-1:0] up_arburst,
    output logic               dn_arvalid,
    input  logic               dn_arready,
    output logic [ID_W-1:0]    dn_arid,
    output logic [ADDR_W-1:0]  dn_araddr,
    output logic [LEN_W-1:0]   dn_arlen,
    output logic [SIZE_W-1:0]  dn_arsize,
    output logic [BURST_W-1:0] dn_arburst,
    input  logic               dn_rvalid,
    output logic               dn_rready,
    input  logic [ID_W-1:0]    dn_rid,
    input  logic [DATA_W-1:0]  dn_rdata,
    input  logic [RESP_W-1:0]  dn_rresp,
    input  logic               dn_rlast,
    output logic               up_rvalid,
    input  logic               up_rready,
    output logic [ID_W-1:0]    up_rid,
    output logic [DATA_W-1:0]  up_rdata,
    output logic [RESP_W-1:0]  up_rresp,
    output logic               up_rlast,
    output logic [CNT_W-1:0]   outs_cnt
);
    ar_pld_t          up_ar_pld, dn_ar_pld;
    r_pld_t           dn_r_pld, up_r_pld;
    logic             ar_in_rdy, ar_room, ar_hs, rlast_hs;
    logic [CNT_W-1:0] outs_cnt_q;

    assign up_ar_pld = '{id: up_arid, addr: up_araddr, len: up_arlen,
                         size: up_arsize, burst: up_arburst};
    assign dn_r_pld  = '{id: dn_rid, data: dn_rdata, resp: dn_rresp, last: dn_rlast};

    assign ar_room    = outs_cnt_q < CNT_W'(MAX_OUTS);
    assign up_arready = ar_in_rdy & ar_room;
    assign ar_hs      = up_arvalid & up_arready;
    assign rlast_hs   = up_rvalid & up_rready & up_rlast;

    // Gating in_valid with the limiter keeps the buffer from accepting a refused AR.
    easyaxi_skid_buf #(.PLD_W(AR_PLD_W)) u_ar_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (up_arvalid & ar_room),
        .in_ready  (ar_in_rdy),
        .in_pld    (up_ar_pld),
        .out_valid (dn_arvalid),
        .out_ready (dn_arready),
        .out_pld   (dn_ar_pld)
    );

    easyaxi_skid_buf #(.PLD_W(R_PLD_W)) u_r_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (dn_rvalid),
        .in_ready  (dn_rready),
        .in_pld    (dn_r_pld),
        .out_valid (up_rvalid),
        .out_ready (up_rready),
        .out_pld   (up_r_pld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            outs_cnt_q <= '0;
        else if (ar_hs != rlast_hs)
            outs_cnt_q <= ar_hs ? outs_cnt_q + 1'b1 : outs_cnt_q - 1'b1;
    end

    assign outs_cnt   = outs_cnt_q;
    assign dn_arid    = dn_ar_pld.id;
    assign dn_araddr  = dn_ar_pld.addr;
    assign dn_arlen   = dn_ar_pld.len;
    assign dn_arsize  = dn_ar_pld.size;
    assign dn_arburst = dn_ar_pld.burst;
    assign up_rid     = up_r_pld.id;
    assign up_rdata   = up_r_pld.data;
    assign up_rresp   = up_r_pld.resp;
    assign up_rlast   = up_r_pld.last;

`ifndef SYNTHESIS
    a_cnt_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (ar_hs && !rlast_hs) |-> (outs_cnt_q < CNT_W'(MAX_OUTS)));
    a_cnt_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (rlast_hs && !ar_hs) |-> (outs_cnt_q != '0));
    a_ar_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (dn_arvalid && !dn_arready) |=> (dn_arvalid && $stable(dn_ar_pld)));
    a_r_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (up_rvalid && !up_rready) |=> (up_rvalid && $stable(up_r_pld)));
`endif
endmodule

// File: tb/tb_easyaxi_rd_slice.sv
// Bench for easyaxi_rd_slice: per-cycle queue model of both channels plus directed and random traffic.
module tb_easyaxi_rd_slice;
    import easyaxi_rd_slice_pkg::*;

    localparam int MAX_OUTS = 4;
    localparam int CNT_W    = 4;
    localparam int N_RAND   = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               up_arvalid, up_arready, dn_arvalid, dn_arready;
    logic               dn_rvalid, dn_rready, up_rvalid, up_rready;
    ar_pld_t            up_ar, dn_ar_o;
    r_pld_t             dn_r, up_r_o;
    logic [ID_W-1:0]    dn_arid, up_rid;
    logic [ADDR_W-1:0]  dn_araddr;
    logic [LEN_W-1:0]   dn_arlen;
    logic [SIZE_W-1:0]  dn_arsize;
    logic [BURST_W-1:0] dn_arburst;
    logic [DATA_W-1:0]  up_rdata;
    logic [RESP_W-1:0]  up_rresp;
    logic               up_rlast;
    logic [CNT_W-1:0]   outs_cnt;

    easyaxi_rd_slice #(.MAX_OUTS(MAX_OUTS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_arvalid(up_arvalid), .up_arready(up_arready),
        .up_arid(up_ar.id), .up_araddr(up_ar.addr), .up_arlen(up_ar.len),
        .up_arsize(up_ar.size), .up_arburst(up_ar.burst),
        .dn_arvalid(dn_arvalid), .dn_arready(dn_arready),
        .dn_arid(dn_arid), .dn_araddr(dn_araddr), .dn_arlen(dn_arlen),
        .dn_arsize(dn_arsize), .dn_arburst(dn_arburst),
        .dn_rvalid(dn_rvalid), .dn_rready(dn_rready),
        .dn_rid(dn_r.id), .dn_rdata(dn_r.data), .dn_rresp(dn_r.resp), .dn_rlast(dn_r.last),
        .up_rvalid(up_rvalid), .up_rready(up_rready),
        .up_rid(up_rid), .up_rdata(up_rdata), .up_rresp(up_rresp), .up_rlast(up_rlast),
        .outs_cnt(outs_cnt)
    );

    assign dn_ar_o = {dn_arid, dn_araddr, dn_arlen, dn_arsize, dn_arburst};
    assign up_r_o  = {up_rid, up_rdata, up_rresp, up_rlast};

    int total = 0;
    int bad   = 0;

    // Reference model: each channel is an in-order FIFO of at most two beats.
    ar_pld_t q_ar[$];
    r_pld_t  q_r[$];
    int      cnt_m = 0;
    bit      live  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply current inputs across one clock edge, update the model, then check every output.
    task automatic cycle();
        bit rst_at_edge;
        rst_at_edge = rst_n;
        if (!rst_n) begin
            q_ar.delete();
            q_r.delete();
            cnt_m = 0;
            live  = 0;
        end else begin
            if (dn_arvalid && dn_arready && q_ar.size() > 0)
                void'(q_ar.pop_front());
            if (up_rvalid && up_rready && q_r.size() > 0) begin
                if (q_r[0].last) cnt_m--;
                void'(q_r.pop_front());
            end
            if (up_arvalid && up_arready) begin
                q_ar.push_back(up_ar);
                cnt_m++;
            end
            if (dn_rvalid && dn_rready)
                q_r.push_back(dn_r);
        end
        @(posedge clk);
        #1;
        if (rst_at_edge) live = 1;
        chk("dn_arvalid", 64'(dn_arvalid), 64'(q_ar.size() > 0));
        if (dn_arvalid && q_ar.size() > 0)
            chk("dn_ar_pld", 64'(dn_ar_o), 64'(q_ar[0]));
        chk("up_rvalid", 64'(up_rvalid), 64'(q_r.size() > 0));
        if (up_rvalid && q_r.size() > 0)
            chk("up_r_pld", 64'(up_r_o), 64'(q_r[0]));
        chk("dn_rready", 64'(dn_rready), 64'(live && q_r.size() < 2));
        chk("up_arready", 64'(up_arready), 64'(live && q_ar.size() < 2 && cnt_m < MAX_OUTS));
        chk("outs_cnt", 64'(outs_cnt), 64'(cnt_m));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        up_arvalid = 1'b0;
        dn_arready = 1'b0;
        dn_rvalid  = 1'b0;
        up_rready  = 1'b0;
        repeat (3) begin
            cycle();
            chk("rst_arvalid", 64'(dn_arvalid), 64'(0));
            chk("rst_rvalid", 64'(up_rvalid), 64'(0));
            chk("rst_arready", 64'(up_arready), 64'(0));
            chk("rst_cnt", 64'(outs_cnt), 64'(0));
        end
        rst_n = 1'b1;
        cycle();
        chk("rel_arready", 64'(up_arready), 64'(1));
        chk("rel_rready", 64'(dn_rready), 64'(1));
        chk("rel_cnt", 64'(outs_cnt), 64'(0));
    endtask

    typedef struct {
        logic              arv;
        logic [ADDR_W-1:0] addr;
        logic              rv;
        int                exp_cnt;
        logic              exp_ardy;
        logic              exp_rvld;
    } vec_t;

    typedef struct {
        logic [ID_W-1:0] id;
        int              len;
    } burst_t;

    initial begin
        vec_t   tbl[13];
        burst_t bq[$];
        int     b, got, held, beat, n_ar, n_dn_ar, n_last;
        bit     dropped, s_hs, m_hs, stall, done, ar_done, ar_take, r_done;

        up_ar = '{id: '0, addr: '0, len: '0, size: 3'd2, burst: 2'd1};
        dn_r  = '{id: '0, data: '0, resp: '0, last: 1'b0};

        // Limiter: four ARs fill the slots, 0x200/0x240 wait; rlast frees one; AR+rlast at 3 holds.
        tbl[0]  = '{1'b1, 32'h100, 1'b0, 1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 32'h140, 1'b0, 2, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'h180, 1'b0, 3, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'h1c0, 1'b0, 4, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h200, 1'b0, 4, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h200, 1'b0, 4, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h200, 1'b1, 4, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 32'h200, 1'b0, 3, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'h200, 1'b0, 4, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h240, 1'b1, 4, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 32'h240, 1'b1, 3, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 32'h240, 1'b0, 3, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 32'h240, 1'b0, 3, 1'b1, 1'b0};

        do_reset();
        dn_arready = 1'b1;
        up_rready  = 1'b1;
        for (int i = 0; i < 13; i++) begin
            up_arvalid = tbl[i].arv;
            up_ar.addr = tbl[i].addr;
            dn_rvalid  = tbl[i].rv;
            dn_r.last  = tbl[i].rv;
            dn_r.data  = DATA_W'(i);
            cycle();
            chk($sformatf("tbl%0d_cnt", i), 64'(outs_cnt), 64'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_arready", i), 64'(up_arready), 64'(tbl[i].exp_ardy));
            chk($sformatf("tbl%0d_rvalid", i), 64'(up_rvalid), 64'(tbl[i].exp_rvld));
        end

        // Reset with three bursts outstanding must clear everything.
        do_reset();

        // Streaming: 16 beats back-to-back, each visible one cycle after it is driven.
        up_rready  = 1'b1;
        dn_arready = 1'b1;
        up_arvalid = 1'b1;
        up_ar.len  = LEN_W'(15);
        cycle();
        up_arvalid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            dn_rvalid = 1'b1;
            dn_r      = '{id: '0, data: DATA_W'(k), resp: '0, last: (k == 15)};
            cycle();
            chk("stream_vld", 64'(up_rvalid), 64'(1));
            chk("stream_dat", 64'(up_rdata), 64'(k));
            chk("stream_cnt", 64'(outs_cnt), 64'(1));
        end
        dn_rvalid = 1'b0;
        cycle();
        chk("stream_end_vld", 64'(up_rvalid), 64'(0));
        chk("stream_end_cnt", 64'(outs_cnt), 64'(0));

        // Backpressure: master stalls 5 cycles mid-burst of 12 beats.
        up_arvalid = 1'b1;
        up_ar.len  = LEN_W'(11);
        cycle();
        up_arvalid = 1'b0;
        b = 0; got = 0; dropped = 0;
        for (int i = 0; i < 40 && got < 12; i++) begin
            up_rready = !(i >= 4 && i < 9);
            dn_rvalid = (b < 12);
            dn_r      = '{id: '0, data: DATA_W'(32'h100 + b), resp: '0, last: (b == 11)};
            s_hs  = dn_rvalid && dn_rready;
            m_hs  = up_rvalid && up_rready;
            stall = up_rvalid && !up_rready;
            held  = int'(up_rdata);
            cycle();
            if (s_hs) b++;
            if (m_hs) got++;
            if (stall)
                chk("stall_stable", 64'(up_rdata), 64'(held));
            if (!dn_rready && !dropped) begin
                dropped = 1;
                chk("buffered_at_drop", 64'(b - got), 64'(2));
            end
        end
        dn_rvalid = 1'b0;
        chk("bp_rready_dropped", 64'(dropped), 64'(1));
        chk("bp_all_delivered", 64'(got), 64'(12));
        chk("bp_cnt", 64'(outs_cnt), 64'(0));

        // Random traffic: bench acts as both master and slave, model checks every cycle.
        do_reset();
        n_ar = 0; n_dn_ar = 0; n_last = 0; beat = 0; done = 0;
        for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
            dn_arready = ($urandom_range(3, 0) != 0);
            up_rready  = ($urandom_range(3, 0) != 0);
            if (!up_arvalid && n_ar < N_RAND && $urandom_range(3, 0) != 0) begin
                up_arvalid = 1'b1;
                up_ar = '{id: ID_W'($urandom), addr: ADDR_W'($urandom),
                          len: LEN_W'($urandom_range(15, 0)), size: SIZE_W'($urandom_range(7, 0)),
                          burst: BURST_W'($urandom_range(2, 0))};
            end
            if (!dn_rvalid && bq.size() > 0 && $urandom_range(3, 0) != 0) begin
                dn_rvalid = 1'b1;
                dn_r = '{id: bq[0].id, data: DATA_W'($urandom), resp: RESP_W'($urandom),
                         last: (beat == bq[0].len)};
            end
            ar_done = up_arvalid && up_arready;
            ar_take = dn_arvalid && dn_arready;
            r_done  = dn_rvalid && dn_rready;
            if (ar_take) bq.push_back('{id: dn_arid, len: int'(dn_arlen)});
            if (up_rvalid && up_rready && up_rlast) n_last++;
            cycle();
            if (ar_done) begin
                up_arvalid = 1'b0;
                n_ar++;
            end
            if (ar_take) n_dn_ar++;
            if (r_done) begin
                dn_rvalid = 1'b0;
                if (dn_r.last) begin
                    void'(bq.pop_front());
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            done = (n_ar == N_RAND) && (bq.size() == 0) && !dn_rvalid &&
                   (q_ar.size() == 0) && (q_r.size() == 0);
        end
        chk("rand_ars_up", 64'(n_ar), 64'(N_RAND));
        chk("rand_ars_dn", 64'(n_dn_ar), 64'(N_RAND));
        chk("rand_rlast_up", 64'(n_last), 64'(N_RAND));
        chk("rand_cnt_end", 64'(outs_cnt), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
